button_conditioner: RTL

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_pkg.sv | 26 ++
 rtl/debounce_chan.sv | 73 +++++++
 rtl/button_conditioner.sv | 106 ++++++++++
 3 files changed

// File: rtl/button_pkg.sv
// Shared definitions for the push-button conditioner: combo FSM state
// type, default tuning constants and a counter-width helper.
package button_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARMING = 2'd1,
      ACTIVE = 2'd2
   } combo_state_t;

   localparam int DEF_N_BTN        = 2;
   localparam int DEF_DEBOUNCE_W   = 16;
   localparam int DEF_DEBOUNCE_CNT = 50000;
   localparam int DEF_COMBO_HOLD   = 8;

   // Bits needed to hold 0..max_val, never less than one bit.
   function automatic int cnt_width(input int max_val);
      int w;
      w = 1;
      while ((1 << w) <= max_val) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/debounce_chan.sv
// One push-button channel: 2-flop synchroniser, stable-count debouncer and
// registered press/release strobes aligned with the debounced level.
module debounce_chan
   import button_pkg::*;
#(
   parameter int DEBOUNCE_W   = DEF_DEBOUNCE_W,
   parameter int DEBOUNCE_CNT = DEF_DEBOUNCE_CNT
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_btn_n,
   output logic o_pressed,
   output logic o_press_pulse,
   output logic o_release_pulse
);

   localparam logic [DEBOUNCE_W-1:0] CNT_LAST = DEBOUNCE_W'(DEBOUNCE_CNT - 1);

   logic                  r_sync1;
   logic                  r_sync2;
   logic                  r_deb;
   logic [DEBOUNCE_W-1:0] r_cnt;
   logic                  r_press_pulse;
   logic                  r_release_pulse;

   logic w_synced;
   logic w_differs;
   logic w_expire;

   // Synchroniser idles at 1 so a reset looks like a released button.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= i_btn_n;
         r_sync2 <= r_sync1;
      end
   end

   assign w_synced  = ~r_sync2;
   assign w_differs = (w_synced != r_deb);
   assign w_expire  = w_differs && (r_cnt == CNT_LAST);

   // Strobes are registered together with r_deb, so they coincide with the
   // first cycle of the new debounced level.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_deb           <= 1'b0;
         r_cnt           <= '0;
         r_press_pulse   <= 1'b0;
         r_release_pulse <= 1'b0;
      end else begin
         r_press_pulse   <= 1'b0;
         r_release_pulse <= 1'b0;
         if (!w_differs) begin
            r_cnt <= '0;
         end else if (w_expire) begin
            r_deb           <= w_synced;
            r_cnt           <= '0;
            r_press_pulse   <= w_synced;
            r_release_pulse <= ~w_synced;
         end else begin
            r_cnt <= r_cnt + DEBOUNCE_W'(1);
         end
      end
   end

   assign o_pressed       = r_deb;
   assign o_press_pulse   = r_press_pulse;
   assign o_release_pulse = r_release_pulse;

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner with a held-combo reset detector;
// release strobes of combo channels are swallowed while the combo is active.
module button_conditioner
   import button_pkg::*;
#(
   parameter int               N_BTN        = DEF_N_BTN,
   parameter int               DEBOUNCE_W   = DEF_DEBOUNCE_W,
   parameter int               DEBOUNCE_CNT = DEF_DEBOUNCE_CNT,
   parameter logic [N_BTN-1:0] COMBO_MASK   = '1,
   parameter int               COMBO_HOLD   = DEF_COMBO_HOLD
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [N_BTN-1:0] i_btn_n,
   output logic [N_BTN-1:0] o_pressed,
   output logic [N_BTN-1:0] o_press_pulse,
   output logic [N_BTN-1:0] o_release_pulse,
   output logic             o_combo_reset,
   output logic [1:0]       o_combo_state
);

   localparam int                HOLD_W    = cnt_width(COMBO_HOLD - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(COMBO_HOLD - 1);

   localparam logic [1:0] S_IDLE   = IDLE;
   localparam logic [1:0] S_ARMING = ARMING;
   localparam logic [1:0] S_ACTIVE = ACTIVE;

   logic [N_BTN-1:0] w_pressed;
   logic [N_BTN-1:0] w_press_pulse;
   logic [N_BTN-1:0] w_release_raw;
   logic             w_full;
   logic             w_none;
   logic             w_active;

   logic [1:0]        r_state;
   logic [HOLD_W-1:0] r_hold;

   for (genvar g = 0; g < N_BTN; g++) begin : g_chan
      debounce_chan #(
         .DEBOUNCE_W   (DEBOUNCE_W),
         .DEBOUNCE_CNT (DEBOUNCE_CNT)
      ) u_chan (
         .i_clk           (i_clk),
         .i_reset         (i_reset),
         .i_btn_n         (i_btn_n[g]),
         .o_pressed       (w_pressed[g]),
         .o_press_pulse   (w_press_pulse[g]),
         .o_release_pulse (w_release_raw[g])
      );
   end

   assign w_full   = ((w_pressed & COMBO_MASK) == COMBO_MASK);
   assign w_none   = ((w_pressed & COMBO_MASK) == '0);
   assign w_active = (r_state == S_ACTIVE);

   // The IDLE cycle that first sees the full combo counts as hold cycle one.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= S_IDLE;
         r_hold  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_full) begin
                  if (COMBO_HOLD == 1) begin
                     r_state <= S_ACTIVE;
                  end else begin
                     r_state <= S_ARMING;
                     r_hold  <= HOLD_W'(1);
                  end
               end
            end
            S_ARMING: begin
               if (!w_full) begin
                  r_state <= S_IDLE;
                  r_hold  <= '0;
               end else if (r_hold == HOLD_LAST) begin
                  r_state <= S_ACTIVE;
                  r_hold  <= '0;
               end else begin
                  r_hold <= r_hold + HOLD_W'(1);
               end
            end
            S_ACTIVE: begin
               if (w_none) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_hold  <= '0;
            end
         endcase
      end
   end

   // The final release of a combo lands while the FSM is still ACTIVE, so
   // masking on the state also covers the exit cycle.
   assign o_release_pulse = w_release_raw & ~(w_active ? COMBO_MASK : '0);
   assign o_pressed       = w_pressed;
   assign o_press_pulse   = w_press_pulse;
   assign o_combo_reset   = w_active;
   assign o_combo_state   = r_state;

endmodule
